hub75_rx_capture: RTL

//  Receiving end of the HUB75 panel interface: oversamples LP_CLK/LATCH/NOE/ROW/RGB0/RGB1 as
//  a panel would, rebuilds each latched line and replays it as pixel writes into a capture RAM.

---
 rtl/hub75_rx_capture.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_rx_capture.sv
// HUB75 receive-side capture: synchronises the panel pins, rebuilds each latched line in
// ping-pong buffers and replays it as {row,col} writes. Optional NOE on-time counter: HUB75_NOE_MEAS_EN.
module hub75_rx_capture #(
    parameter int NUM_COLS    = 64,
    parameter int ROW_BITS    = 5,
    parameter int COL_BITS    = 6,
    parameter int PLANES      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ON_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         LP_CLK,
    input  logic                         LATCH,
    input  logic                         NOE,
    input  logic [ROW_BITS-1:0]          ROW,
    input  logic [2:0]                   RGB0,
    input  logic [2:0]                   RGB1,
    input  logic                         clr_err,
    output logic                         wr_en,
    output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
    output logic [$clog2(PLANES)-1:0]    wr_plane,
    output logic [5:0]                   wr_data,
    output logic                         line_done,
    output logic                         err_len,
    output logic                         err_ovr,
    output logic [ON_W-1:0]              on_time,
    output logic                         on_valid
);

    localparam int IN_W = 3 + ROW_BITS + 6;
    localparam int PB   = $clog2(PLANES);
    localparam logic [COL_BITS:0]   FULL_CNT = (COL_BITS+1)'(NUM_COLS);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);
    localparam logic [PB-1:0]       LAST_PL  = PB'(PLANES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [IN_W-1:0]     sync_r [SYNC_STAGES];
    logic [IN_W-1:0]     sync_s;
    logic                lp_s;
    logic                latch_s;
    logic                noe_s;
    logic [ROW_BITS-1:0] row_s;
    logic [5:0]          rgb_s;

    logic                lp_prev_r;
    logic                latch_prev_r;
    logic [COL_BITS:0]   cnt_r;
    logic                extra_r;
    logic                fill_sel_r;
    logic [PB-1:0]       plane_r;
    logic [ROW_BITS-1:0] last_row_r;
    logic                last_valid_r;
    logic [COL_BITS-1:0] col_r;
    state_t              state_r;
    logic [5:0]          line_buf_r [2][NUM_COLS];

    logic                lp_rise_s;
    logic                latch_rise_s;
    logic                pix_store_s;
    logic [COL_BITS-1:0] wr_col_s;
    logic [COL_BITS:0]   cnt_eff_s;
    logic                extra_eff_s;
    logic                busy_s;
    logic                len_bad_s;
    logic                accept_s;
    logic                same_row_s;
    logic [PB-1:0]       plane_next_s;
    logic [5:0]          first_data_s;
    logic                drain_sel_s;
    logic [COL_BITS-1:0] next_col_s;
    logic [5:0]          next_data_s;

    // Input synchroniser: every pin gets the same delay so data stays aligned with its strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {IN_W{1'b0}};
            end
        end else begin
            sync_r[0] <= {LP_CLK, LATCH, NOE, ROW, RGB0, RGB1};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_s  = sync_r[SYNC_STAGES-1];
    assign lp_s    = sync_s[IN_W-1];
    assign latch_s = sync_s[IN_W-2];
    assign noe_s   = sync_s[IN_W-3];
    assign row_s   = sync_s[ROW_BITS+5:6];
    assign rgb_s   = sync_s[5:0];

    assign lp_rise_s    = lp_s & ~lp_prev_r;
    assign latch_rise_s = latch_s & ~latch_prev_r;

    // A pixel arriving with the latch is counted before the latch is judged.
    assign pix_store_s  = lp_rise_s && (cnt_r < FULL_CNT);
    assign wr_col_s     = LAST_COL - cnt_r[COL_BITS-1:0];
    assign cnt_eff_s    = pix_store_s ? (cnt_r + (COL_BITS+1)'(1)) : cnt_r;
    assign extra_eff_s  = extra_r | (lp_rise_s && (cnt_r == FULL_CNT));
    assign busy_s       = (state_r == ST_DRAIN);
    assign len_bad_s    = latch_rise_s && ((cnt_eff_s != FULL_CNT) || extra_eff_s);
    assign accept_s     = latch_rise_s && !len_bad_s && !busy_s;

    assign same_row_s   = last_valid_r && (row_s == last_row_r);
    assign plane_next_s = !same_row_s ? {PB{1'b0}} :
                          (plane_r == LAST_PL) ? {PB{1'b0}} : (plane_r + PB'(1));

    // Column 0 may be written on the very edge that latches the line; forward it.
    assign first_data_s = (pix_store_s && (wr_col_s == {COL_BITS{1'b0}})) ?
                          rgb_s : line_buf_r[fill_sel_r][0];
    assign drain_sel_s  = ~fill_sel_r;
    assign next_col_s   = col_r + COL_BITS'(1);
    assign next_data_s  = line_buf_r[drain_sel_s][next_col_s];

    // Shift-side storage into the buffer currently being filled.
    always_ff @(posedge clk) begin
        if (pix_store_s) begin
            line_buf_r[fill_sel_r][wr_col_s] <= rgb_s;
        end
    end

    // Edge tracking, pulse counting, latch evaluation, error flags and the drain FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_prev_r    <= 1'b0;
            latch_prev_r <= 1'b0;
            cnt_r        <= {(COL_BITS+1){1'b0}};
            extra_r      <= 1'b0;
            fill_sel_r   <= 1'b0;
            plane_r      <= {PB{1'b0}};
            last_row_r   <= {ROW_BITS{1'b0}};
            last_valid_r <= 1'b0;
            col_r        <= {COL_BITS{1'b0}};
            state_r      <= ST_IDLE;
            wr_en        <= 1'b0;
            wr_addr      <= {(ROW_BITS+COL_BITS){1'b0}};
            wr_plane     <= {PB{1'b0}};
            wr_data      <= 6'd0;
            line_done    <= 1'b0;
            err_len      <= 1'b0;
            err_ovr      <= 1'b0;
        end else begin
            lp_prev_r    <= lp_s;
            latch_prev_r <= latch_s;

            if (latch_rise_s) begin
                cnt_r   <= {(COL_BITS+1){1'b0}};
                extra_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_eff_s;
                extra_r <= extra_eff_s;
            end

            if (len_bad_s) begin
                err_len <= 1'b1;
            end else if (clr_err) begin
                err_len <= 1'b0;
            end

            if (latch_rise_s && busy_s) begin
                err_ovr <= 1'b1;
            end else if (clr_err) begin
                err_ovr <= 1'b0;
            end

            if (accept_s) begin
                fill_sel_r   <= ~fill_sel_r;
                plane_r      <= plane_next_s;
                last_row_r   <= row_s;
                last_valid_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_DRAIN;
                        col_r     <= {COL_BITS{1'b0}};
                        wr_en     <= 1'b1;
                        wr_addr   <= {row_s, {COL_BITS{1'b0}}};
                        wr_plane  <= plane_next_s;
                        wr_data   <= first_data_s;
                        line_done <= (NUM_COLS == 1);
                    end else begin
                        wr_en     <= 1'b0;
                        line_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (col_r == LAST_COL) begin
                        state_r   <= ST_IDLE;
                        wr_en     <= 1'b0;
                        line_done <= 1'b0;
                    end else begin
                        col_r     <= next_col_s;
                        wr_en     <= 1'b1;
                        wr_addr   <= {last_row_r, next_col_s};
                        wr_data   <= next_data_s;
                        line_done <= (next_col_s == LAST_COL);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    wr_en     <= 1'b0;
                    line_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HUB75_NOE_MEAS_EN
    logic [ON_W-1:0] on_cnt_r;

    // NOE-low cycle counter: restarts on each accepted line, reported at the next latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            on_cnt_r <= {ON_W{1'b0}};
            on_time  <= {ON_W{1'b0}};
            on_valid <= 1'b0;
        end else begin
            on_valid <= latch_rise_s;
            if (latch_rise_s) begin
                on_time <= on_cnt_r;
            end
            if (accept_s) begin
                on_cnt_r <= {ON_W{1'b0}};
            end else if (!noe_s && (on_cnt_r != {ON_W{1'b1}})) begin
                on_cnt_r <= on_cnt_r + ON_W'(1);
            end
        end
    end
`else
    assign on_time  = {ON_W{1'b0}};
    assign on_valid = noe_s & 1'b0;
`endif

endmodule
